board_access_ctrl: RTL and testbench
====================================

# board_access_ctrl

Owns the 16x16 game-board cell storage (3-bit cell codes) and shares it between NREQ requesters (red player logic, blue player logic, display scanner) through a round-robin arbiter, one access per cycle. Runs a clear sequencer that writes CELL_EMPTY to every cell after reset or on command. Maintains live red/blue territory counts for scoring. Sits between the game-logic blocks and the display path.

## Interface
- WIDTH, 16, board columns
- HEIGHT, 16, board rows
- NREQ, 3, number of requesters (0 red, 1 blue, 2 display)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- clear_req  in  1  one-cycle pulse: start board clear
- busy  out  1  high while clearing
- req_valid  in  NREQ  per-requester access request
- req_we  in  NREQ  1 = write, 0 = read
- req_x  in  NREQ*XW  column, XW = clog2(WIDTH), requester i at [i*XW +: XW]
- req_y  in  NREQ*YW  row, YW = clog2(HEIGHT)
- req_wdata  in  NREQ*3  write cell code
- req_ready  out  NREQ  one-hot grant; access accepted when req_valid[i] & req_ready[i]
- rsp_valid  out  NREQ  read data valid for requester i
- rsp_data  out  3  read cell code (shared; qualified by rsp_valid)
- red_cells  out  9  number of cells holding CELL_RED_TAKEN
- blue_cells  out  9  number of cells holding CELL_BLUE_TAKEN

## Operation
- Cell codes: 0 unused, 1 EMPTY, 2 RED_TAKEN, 3 BLUE_TAKEN, 4 RED_ON, 5 BLUE_ON, 6 RED_BOMB, 7 BLUE_BOMB.
- Address = y*WIDTH + x. Coordinates with x >= WIDTH or y >= HEIGHT: still granted; writes dropped, reads return 0.
- FSM states CLEAR and RUN. Reset -> CLEAR, clear_addr = 0.
- CLEAR: each cycle write EMPTY at clear_addr and increment. After address WIDTH*HEIGHT-1 is written -> RUN next cycle. busy = 1, req_ready = 0. clear_req ignored in CLEAR.
- RUN: busy = 0. clear_req -> CLEAR from address 0 next cycle. No grant is issued in the cycle clear_req is sampled.
- Arbitration (RUN only): among asserted req_valid, grant the first index after last_grant, wrapping modulo NREQ. last_grant updates only on a grant. Reset value NREQ-1, so requester 0 wins first. req_ready is combinational from req_valid and last_grant, and is at most one-hot.
- Write: cell updated at the accepting edge. Counts update at the same edge: decrement the counter of the old code if it is 2 or 3, increment the counter of the new code if it is 2 or 3. Writing the same code leaves counts unchanged.
- Read: rsp_valid[i] and rsp_data registered, one cycle after acceptance.
- Counts are cleared to 0 when CLEAR is entered.

## Timing
- Reset values: busy = 1, req_ready = 0, rsp_valid = 0, rsp_data = 0, red_cells = 0, blue_cells = 0, clear_addr = 0.
- Clear takes exactly WIDTH*HEIGHT cycles (256 by default). The first grant is possible in cycle 256 after reset deasserts.
- Read latency 1. A read accepted in the cycle after a write to the same cell returns the new data.
- A read accepted in the last RUN cycle before CLEAR still produces its rsp_valid pulse.
- Reset asserted mid-clear or mid-RUN restarts CLEAR at address 0 and drops any pending rsp_valid.
- A requester that holds req_valid is granted within NREQ cycles while in RUN.

## Structure
- board_pkg: cell-code constants, default WIDTH/HEIGHT, XW/YW derivation, FSM state enum.
- Sub-module rr_arbiter (NREQ, req vector -> one-hot grant, internal last_grant register, enable input). The top module holds the storage array, clear FSM, counters and response register.

## Test plan
- Reset, then hold idle: busy = 1 for exactly 256 cycles. Afterwards, reads of (0,0), (15,15) and (7,3) all return 1.
- Requesters 0, 1 and 2 all hold req_valid continuously: grant order 0, 1, 2, 0, 1, 2; each rsp_valid one cycle after its grant.
- Requester 0 writes 2 at (3,4), then 3 at (3,4), then requester 1 writes 2 at (5,5): red_cells/blue_cells go 1/0, 0/1, 1/1.
- Write 6 at (1,1) and read (1,1) in the next cycle: read returns 6, counts unchanged.
- Assert clear_req while requester 1 is requesting with red_cells = 5: no grant for 256 cycles, counts = 0, then requester 1 is granted and the read returns 1.
- Assert reset at clear_addr = 100: busy stays high for 256 full cycles after reset deasserts.

Source files
------------

// File: rtl/board_pkg.sv
// Shared constants and types for the game-board access controller.
package board_pkg;

  localparam int unsigned BOARD_WIDTH  = 16;
  localparam int unsigned BOARD_HEIGHT = 16;

  // 3-bit cell codes stored in the board array.
  localparam logic [2:0] CELL_UNUSED     = 3'd0;
  localparam logic [2:0] CELL_EMPTY      = 3'd1;
  localparam logic [2:0] CELL_RED_TAKEN  = 3'd2;
  localparam logic [2:0] CELL_BLUE_TAKEN = 3'd3;
  localparam logic [2:0] CELL_RED_ON     = 3'd4;
  localparam logic [2:0] CELL_BLUE_ON    = 3'd5;
  localparam logic [2:0] CELL_RED_BOMB   = 3'd6;
  localparam logic [2:0] CELL_BLUE_BOMB  = 3'd7;

  // Index width for n items; never returns zero so single-entry vectors stay legal.
  function automatic int unsigned coord_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [0:0] {
    StClear,
    StRun
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant rotating from the index after the last winner.
module rr_arbiter
  import board_pkg::*;
#(
  parameter int unsigned NREQ = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant
);

  localparam int unsigned IW = coord_width(NREQ);

  logic [IW-1:0] last_grant;
  logic [IW-1:0] next_grant;
  logic          found;
  int            idx;

  // Scan requesters starting just after last_grant, wrapping; first asserted one wins.
  always_comb begin
    grant      = '0;
    next_grant = last_grant;
    found      = 1'b0;
    idx        = 0;
    for (int off = 1; off <= int'(NREQ); off++) begin
      idx = (int'(last_grant) + off) % int'(NREQ);
      if (enable && !found && req[IW'(idx)]) begin
        grant[IW'(idx)] = 1'b1;
        next_grant      = IW'(idx);
        found           = 1'b1;
      end
    end
  end

  // Remember the winner; reset to the last index so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= IW'(NREQ - 1);
    end else if (found) begin
      last_grant <= next_grant;
    end
  end

endmodule

// File: rtl/board_access_ctrl.sv
// Game-board cell storage shared by several requesters, with clear sequencer
// and live red/blue territory counters.
module board_access_ctrl
  import board_pkg::*;
#(
  parameter int unsigned WIDTH  = BOARD_WIDTH,
  parameter int unsigned HEIGHT = BOARD_HEIGHT,
  parameter int unsigned NREQ   = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                clear_req,
  output logic                                busy,
  input  logic [NREQ-1:0]                     req_valid,
  input  logic [NREQ-1:0]                     req_we,
  input  logic [NREQ*coord_width(WIDTH)-1:0]  req_x,
  input  logic [NREQ*coord_width(HEIGHT)-1:0] req_y,
  input  logic [NREQ*3-1:0]                   req_wdata,
  output logic [NREQ-1:0]                     req_ready,
  output logic [NREQ-1:0]                     rsp_valid,
  output logic [2:0]                          rsp_data,
  output logic [8:0]                          red_cells,
  output logic [8:0]                          blue_cells
);

  localparam int unsigned XW    = coord_width(WIDTH);
  localparam int unsigned YW    = coord_width(HEIGHT);
  localparam int unsigned CELLS = WIDTH * HEIGHT;
  localparam int unsigned AW    = coord_width(CELLS);

  state_e          state;
  logic [AW-1:0]   clear_addr;
  logic [2:0]      mem [CELLS];

  logic [NREQ-1:0] grant;
  logic            arb_en;
  logic            sel_we;
  logic [XW-1:0]   sel_x;
  logic [YW-1:0]   sel_y;
  logic [2:0]      sel_wdata;
  logic            in_range;
  logic [AW-1:0]   acc_addr;
  logic            accept;
  logic            wr_fire;
  logic            rd_fire;
  logic [2:0]      old_code;
  logic [8:0]      red_next;
  logic [8:0]      blue_next;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [2:0]      mem_wdata;

  // No grants while clearing, nor in the cycle a clear command is taken.
  assign arb_en    = (state == StRun) && !clear_req;
  assign req_ready = grant;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .enable(arb_en),
    .req   (req_valid),
    .grant (grant)
  );

  // Route the granted requester's fields onto the single access port.
  always_comb begin
    sel_we    = 1'b0;
    sel_x     = '0;
    sel_y     = '0;
    sel_wdata = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant[i]) begin
        sel_we    = req_we[i];
        sel_x     = req_x[i*XW +: XW];
        sel_y     = req_y[i*YW +: YW];
        sel_wdata = req_wdata[i*3 +: 3];
      end
    end
  end

  // Decode address; off-board coordinates are granted but never touch storage.
  always_comb begin
    in_range = (32'(sel_x) < WIDTH) && (32'(sel_y) < HEIGHT);
    acc_addr = in_range ? AW'(32'(sel_y) * WIDTH + 32'(sel_x)) : '0;
    accept   = |grant;
    wr_fire  = accept && sel_we && in_range;
    rd_fire  = accept && !sel_we;
    old_code = mem[acc_addr];
  end

  // Territory count deltas: retire the old code, credit the new one.
  always_comb begin
    red_next  = red_cells;
    blue_next = blue_cells;
    if (old_code == CELL_RED_TAKEN)   red_next  = red_next - 9'd1;
    if (old_code == CELL_BLUE_TAKEN)  blue_next = blue_next - 9'd1;
    if (sel_wdata == CELL_RED_TAKEN)  red_next  = red_next + 9'd1;
    if (sel_wdata == CELL_BLUE_TAKEN) blue_next = blue_next + 9'd1;
  end

  // Single write port shared by the clear sequencer and granted writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = acc_addr;
    mem_wdata = sel_wdata;
    if (!reset) begin
      if (state == StClear) begin
        mem_we    = 1'b1;
        mem_waddr = clear_addr;
        mem_wdata = CELL_EMPTY;
      end else if (wr_fire) begin
        mem_we = 1'b1;
      end
    end
  end

  // Board storage.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Clear/run FSM with registered busy and territory counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StClear;
      clear_addr <= '0;
      busy       <= 1'b1;
      red_cells  <= '0;
      blue_cells <= '0;
    end else begin
      unique case (state)
        StClear: begin
          if (clear_addr == AW'(CELLS - 1)) begin
            state      <= StRun;
            busy       <= 1'b0;
            clear_addr <= '0;
          end else begin
            clear_addr <= clear_addr + AW'(1);
          end
        end
        StRun: begin
          if (clear_req) begin
            state      <= StClear;
            busy       <= 1'b1;
            clear_addr <= '0;
            red_cells  <= '0;
            blue_cells <= '0;
          end else if (wr_fire) begin
            red_cells  <= red_next;
            blue_cells <= blue_next;
          end
        end
        default: begin
          state <= StClear;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // Read response register: one cycle after acceptance, off-board reads return 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= rd_fire ? grant : '0;
      if (rd_fire) begin
        rsp_data <= in_range ? old_code : CELL_UNUSED;
      end
    end
  end

endmodule

// File: tb/tb_board_access_ctrl.sv
// Scoreboard bench for board_access_ctrl: model predicts grants, cell contents and counts.
module tb_board_access_ctrl;

  localparam int NR    = 3;
  localparam int XW    = 4;
  localparam int YW    = 4;
  localparam int CELLS = 256;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            clear_req = 1'b0;
  logic            busy;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_we = '0;
  logic [NR*XW-1:0] req_x = '0;
  logic [NR*YW-1:0] req_y = '0;
  logic [NR*3-1:0] req_wdata = '0;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   rsp_valid;
  logic [2:0]      rsp_data;
  logic [8:0]      red_cells;
  logic [8:0]      blue_cells;

  always #5 clk = ~clk;

  board_access_ctrl #(
    .WIDTH (16),
    .HEIGHT(16),
    .NREQ  (NR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .busy      (busy),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .red_cells (red_cells),
    .blue_cells(blue_cells)
  );

  int checks = 0;
  int passed = 0;

  // Reference model.
  logic [2:0] mdl [CELLS];
  int         mred;
  int         mblue;
  int         mlast;

  typedef struct {
    logic [2:0] mask;
    logic [2:0] data;
  } rsp_t;
  rsp_t sb[$];

  logic [2:0] obs_g, obs_rv, obs_rd, exp_g;

  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) mdl[i] = 3'd1;
    mred  = 0;
    mblue = 0;
  endtask

  task automatic model_reset();
    model_clear();
    mlast = NR - 1;
    sb.delete();
  endtask

  task automatic set_req(input int r, input bit v, input bit we, input int x, input int y,
                         input int d);
    req_valid[r]          = v;
    req_we[r]             = we;
    req_x[r*XW +: XW]     = 4'(x);
    req_y[r*YW +: YW]     = 4'(y);
    req_wdata[r*3 +: 3]   = 3'(d);
  endtask

  // Predict this cycle's grant from the driven requests and apply it to the model.
  task automatic model_step(input bit run);
    int sel;
    int a;
    logic [2:0] d;
    exp_g = '0;
    sel   = -1;
    if (run) begin
      for (int off = 1; off <= NR; off++) begin
        int idx;
        idx = (mlast + off) % NR;
        if (req_valid[idx] && sel < 0) sel = idx;
      end
    end
    if (sel >= 0) begin
      exp_g[sel] = 1'b1;
      mlast      = sel;
      a = int'(req_y[sel*YW +: YW]) * 16 + int'(req_x[sel*XW +: XW]);
      d = req_wdata[sel*3 +: 3];
      if (req_we[sel]) begin
        if (mdl[a] == 3'd2) mred--;
        if (mdl[a] == 3'd3) mblue--;
        if (d == 3'd2) mred++;
        if (d == 3'd3) mblue++;
        mdl[a] = d;
      end else begin
        sb.push_back('{mask: exp_g, data: mdl[a]});
      end
    end
  endtask

  // One clock: sample combinational grant, then registered outputs after the edge.
  task automatic cycle();
    #1;
    obs_g = req_ready;
    @(posedge clk);
    #1;
    obs_rv = rsp_valid;
    obs_rd = rsp_data;
  endtask

  task automatic test_reset();
    int n;
    int bad;
    reset = 1'b1;
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else passed++;
    checks++; if (req_ready !== 3'b000) $display("FAIL reset_ready: got %b want 000", req_ready);
    else passed++;
    checks++; if (rsp_valid !== 3'b000) $display("FAIL reset_rsp_valid: got %b want 000",
                                                rsp_valid); else passed++;
    checks++; if (rsp_data !== 3'd0) $display("FAIL reset_rsp_data: got %0d want 0", rsp_data);
    else passed++;
    checks++; if (red_cells !== 9'd0 || blue_cells !== 9'd0)
      $display("FAIL reset_counts: got %0d/%0d want 0/0", red_cells, blue_cells); else passed++;
    reset = 1'b0;
    model_reset();
    n   = 0;
    bad = 0;
    while (busy === 1'b1 && n < 400) begin
      if (req_ready !== 3'b000) bad++;
      n++;
      @(posedge clk);
      #1;
    end
    checks++; if (n != 256) $display("FAIL clear_len: got %0d cycles want 256", n); else passed++;
    checks++; if (bad != 0) $display("FAIL clear_no_grant: got %0d grants want 0", bad);
    else passed++;
    checks++; if (req_ready !== 3'b001) $display("FAIL first_grant: got %b want 001", req_ready);
    else passed++;
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [2:0] order [6];
    rsp_t e;
    order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    set_req(0, 1, 0, 0, 0, 0);
    set_req(1, 1, 0, 1, 0, 0);
    set_req(2, 1, 0, 2, 0, 0);
    for (int k = 0; k < 6; k++) begin
      model_step(1);
      cycle();
      checks++;
      if (obs_g !== exp_g || obs_g !== order[k])
        $display("FAIL rr_grant[%0d]: got %b want %b", k, obs_g, order[k]);
      else passed++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (obs_rv !== e.mask || obs_rd !== e.data)
          $display("FAIL rr_rsp[%0d]: got valid=%b data=%0d want valid=%b data=%0d",
                   k, obs_rv, obs_rd, e.mask, e.data);
        else passed++;
      end
    end
    req_valid = '0;
  endtask

  task automatic test_clear_reads();
    int xs [3];
    int ys [3];
    rsp_t e;
    xs = '{0, 15, 7};
    ys = '{0, 15, 3};
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1, 0, xs[k], ys[k], 0);
      model_step(1);
      cycle();
      req_valid = '0;
      checks++; if (obs_g !== exp_g) $display("FAIL rd_grant[%0d]: got %b want %b", k, obs_g,
                                              exp_g); else passed++;
      e = sb.pop_front();
      checks++;
      if (obs_rv !== e.mask || obs_rd !== 3'd1)
        $display("FAIL rd_empty[%0d]: got valid=%b data=%0d want valid=%b data=1",
                 k, obs_rv, obs_rd, e.mask);
      else passed++;
    end
  endtask

  task automatic test_counts();
    int tr [3];
    int tx [3];
    int ty [3];
    int td [3];
    int er [3];
    int eb [3];
    tr = '{0, 0, 1}; tx = '{3, 3, 5}; ty = '{4, 4, 5}; td = '{2, 3, 2};
    er = '{1, 0, 1}; eb = '{0, 1, 1};
    for (int k = 0; k < 3; k++) begin
      set_req(tr[k], 1, 1, tx[k], ty[k], td[k]);
      model_step(1);
      cycle();
      req_valid = '0;
      checks++; if (obs_g !== exp_g) $display("FAIL wr_grant[%0d]: got %b want %b", k, obs_g,
                                              exp_g); else passed++;
      checks++;
      if (int'(red_cells) != er[k] || int'(blue_cells) != eb[k] ||
          int'(red_cells) != mred || int'(blue_cells) != mblue)
        $display("FAIL counts[%0d]: got %0d/%0d want %0d/%0d", k, red_cells, blue_cells,
                 er[k], eb[k]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    rsp_t e;
    set_req(0, 1, 1, 1, 1, 6);
    model_step(1);
    cycle();
    req_valid = '0;
    set_req(1, 1, 0, 1, 1, 0);
    model_step(1);
    cycle();
    req_valid = '0;
    checks++; if (obs_g !== exp_g) $display("FAIL b2b_grant: got %b want %b", obs_g, exp_g);
    else passed++;
    e = sb.pop_front();
    checks++;
    if (obs_rv !== e.mask || obs_rd !== 3'd6)
      $display("FAIL b2b_rsp: got valid=%b data=%0d want valid=%b data=6", obs_rv, obs_rd,
               e.mask);
    else passed++;
    checks++;
    if (int'(red_cells) != mred || int'(blue_cells) != mblue)
      $display("FAIL b2b_counts: got %0d/%0d want %0d/%0d", red_cells, blue_cells, mred, mblue);
    else passed++;
  endtask

  task automatic test_clear_cmd();
    int bad;
    rsp_t e;
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1, 1, 8 + k, 0, 2);
      model_step(1);
      cycle();
      req_valid = '0;
    end
    checks++; if (red_cells !== 9'd5 || mred != 5)
      $display("FAIL pre_clear_red: got %0d want 5", red_cells); else passed++;
    set_req(1, 1, 0, 9, 9, 0);
    clear_req = 1'b1;
    model_step(0);
    cycle();
    clear_req = 1'b0;
    model_clear();
    checks++; if (obs_g !== 3'b000) $display("FAIL clear_cycle_grant: got %b want 000", obs_g);
    else passed++;
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      model_step(0);
      cycle();
      if (obs_g !== 3'b000 || red_cells !== 9'd0 || blue_cells !== 9'd0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL clear_cmd_quiet: got %0d bad cycles want 0", bad);
    else passed++;
    model_step(1);
    cycle();
    req_valid = '0;
    checks++; if (obs_g !== 3'b010) $display("FAIL post_clear_grant: got %b want 010", obs_g);
    else passed++;
    e = sb.pop_front();
    checks++;
    if (obs_rv !== 3'b010 || obs_rd !== 3'd1 || e.data !== 3'd1)
      $display("FAIL post_clear_rsp: got valid=%b data=%0d want valid=010 data=1", obs_rv,
               obs_rd);
    else passed++;
  endtask

  task automatic test_reset_midclear();
    int n;
    rsp_t e;
    // Read accepted alongside reset must not produce a response.
    set_req(0, 1, 0, 0, 0, 0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    req_valid = '0;
    model_reset();
    checks++; if (obs_rv !== 3'b000) $display("FAIL reset_drops_rsp: got %b want 000", obs_rv);
    else passed++;
    repeat (100) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    model_reset();
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      n++;
      @(posedge clk);
      #1;
    end
    checks++; if (n != 256) $display("FAIL midclear_len: got %0d cycles want 256", n);
    else passed++;
    set_req(2, 1, 0, 3, 4, 0);
    model_step(1);
    cycle();
    req_valid = '0;
    e = sb.pop_front();
    checks++;
    if (obs_rv !== 3'b100 || obs_rd !== e.data || obs_rd !== 3'd1)
      $display("FAIL midclear_read: got valid=%b data=%0d want valid=100 data=1", obs_rv,
               obs_rd);
    else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_clear_reads();
    test_counts();
    test_back_to_back();
    test_clear_cmd();
    test_reset_midclear();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
